// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle RV32I controller.
// The master side is the control FSM. The slave side is the datapath and memory.
interface multicycle_control_if #(parameter int CNT_W = 32) ();
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       ALUop;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic             illegal_instr;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, ALUop, reg_write, wb_sel,
           illegal_instr, instret
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, ALUop, reg_write, wb_sel,
           illegal_instr, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: fetch/decode/execute/mem/wb sequencing,
// retired-instruction counter and sticky illegal-opcode flag.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_if.master bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, LUI, AUIPC, WB_ALU, MEM_ADDR,
    MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL, JALR, ILLEGAL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  logic             retire;

  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_R:              return EXEC_R;
      OP_I:              return EXEC_I;
      OP_LOAD, OP_STORE: return MEM_ADDR;
      OP_BR:             return BRANCH;
      OP_JAL:            return JAL;
      OP_JALR:           return JALR;
      OP_LUI:            return LUI;
      OP_AUIPC:          return AUIPC;
      default:           return ILLEGAL;
    endcase
  endfunction

  // Retire happens on the last cycle of each instruction, while the FSM leaves for FETCH.
  always_comb begin
    retire = 1'b0;
    case (state)
      WB_ALU, WB_MEM, BRANCH, JAL, JALR: retire = 1'b1;
      MEM_WR:                            retire = bus.mem_ready;
      default:                           retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) instret_q <= instret_q + CNT_W'(1);
      case (state)
        FETCH:    if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          state <= decode_next(bus.opcode);
          if (decode_next(bus.opcode) == ILLEGAL) illegal_q <= 1'b1;
        end
        EXEC_R, EXEC_I, LUI, AUIPC: state <= WB_ALU;
        MEM_ADDR: state <= (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        MEM_RD:   if (bus.mem_ready) state <= WB_MEM;
        MEM_WR:   if (bus.mem_ready) state <= FETCH;
        ILLEGAL:  state <= ILLEGAL;
        default:  state <= FETCH;
      endcase
    end
  end

  // Moore decode. Only ir_write/pc_write in FETCH and pc_write in BRANCH depend on inputs.
  // Everything is forced low while rst is high, so a pending memory request drops in the reset cycle.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.addr_sel  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 1'b0;
    bus.alu_src_a = 2'b00;
    bus.alu_src_b = 2'b00;
    bus.ALUop     = 2'b00;
    bus.reg_write = 1'b0;
    bus.wb_sel    = 2'b00;
    if (!rst) begin
      case (state)
        FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_a = 2'b11;
          bus.alu_src_b = 2'b01;
        end
        EXEC_R: begin
          bus.alu_src_a = 2'b01;
          bus.ALUop     = 2'b10;
        end
        EXEC_I: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
          bus.ALUop     = 2'b11;
        end
        LUI: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
        end
        AUIPC: begin
          bus.alu_src_a = 2'b11;
          bus.alu_src_b = 2'b01;
        end
        WB_ALU: bus.reg_write = 1'b1;
        MEM_ADDR: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
        end
        MEM_RD: begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
        end
        WB_MEM: begin
          bus.reg_write = 1'b1;
          bus.wb_sel    = 2'b01;
        end
        MEM_WR: begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
          bus.mem_we   = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a = 2'b01;
          bus.ALUop     = 2'b01;
          bus.pc_write  = bus.branch_taken;
          bus.pc_src    = 1'b1;
        end
        JAL: begin
          bus.reg_write = 1'b1;
          bus.wb_sel    = 2'b10;
          bus.pc_write  = 1'b1;
          bus.pc_src    = 1'b1;
        end
        JALR: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
          bus.pc_write  = 1'b1;
          bus.reg_write = 1'b1;
          bus.wb_sel    = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign bus.instret       = instret_q;
  assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. It runs with CNT_W=4 so that instret wraps quickly.
module tb_multicycle_control;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(CNT_W)) bus ();
  multicycle_control #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Field order: mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, src_a, src_b, ALUop, reg_write, wb_sel
  logic [14:0] ctl;
  assign ctl = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.alu_src_a, bus.alu_src_b, bus.ALUop, bus.reg_write, bus.wb_sel};

  localparam logic [14:0] C_ZERO   = '0;
  localparam logic [14:0] C_F_WAIT = {6'b100000, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] C_F_GO   = {6'b100110, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] C_DEC    = {6'b000000, 2'b11, 2'b01, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] C_EXR    = {6'b000000, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00};
  localparam logic [14:0] C_EXI    = {6'b000000, 2'b01, 2'b01, 2'b11, 1'b0, 2'b00};
  localparam logic [14:0] C_LUI    = {6'b000000, 2'b10, 2'b01, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] C_AUIPC  = {6'b000000, 2'b11, 2'b01, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] C_WBALU  = {6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
  localparam logic [14:0] C_MADDR  = {6'b000000, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] C_MRD    = {6'b101000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] C_WBMEM  = {6'b000000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01};
  localparam logic [14:0] C_MWR    = {6'b111000, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
  localparam logic [14:0] C_BR_T   = {6'b000011, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00};
  localparam logic [14:0] C_BR_NT  = {6'b000001, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00};
  localparam logic [14:0] C_JAL    = {6'b000011, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10};
  localparam logic [14:0] C_JALR   = {6'b000010, 2'b01, 2'b01, 2'b00, 1'b1, 2'b10};

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.opcode = 7'b0;
    bus.branch_taken = 1'b0;
    bus.mem_ready = 1'b0;
    cyc();
    chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
    chk("rst_instret", 32'(bus.instret), 0);
    chk("rst_illegal", 32'(bus.illegal_instr), 0);
    rst = 1'b0; #1;
    chk("fetch_wait", 32'(ctl), 32'(C_F_WAIT));
    cyc(); cyc();
    chk("fetch_stall", 32'(ctl), 32'(C_F_WAIT));

    // R-type, 4 cycles
    bus.mem_ready = 1'b1; bus.opcode = 7'b0110011; #1;
    chk("fetch_go", 32'(ctl), 32'(C_F_GO));
    cyc(); chk("r_decode", 32'(ctl), 32'(C_DEC));
    cyc(); chk("r_exec", 32'(ctl), 32'(C_EXR));
    cyc(); chk("r_wb", 32'(ctl), 32'(C_WBALU));
    chk("r_instret_pre", 32'(bus.instret), 0);
    cyc(); chk("r_back_fetch", 32'(ctl), 32'(C_F_GO));
    chk("r_instret", 32'(bus.instret), 1);

    // I-type
    bus.opcode = 7'b0010011;
    cyc(); cyc(); chk("i_exec", 32'(ctl), 32'(C_EXI));
    cyc(); chk("i_wb", 32'(ctl), 32'(C_WBALU));
    cyc(); chk("i_instret", 32'(bus.instret), 2);

    // LUI and AUIPC
    bus.opcode = 7'b0110111;
    cyc(); cyc(); chk("lui_exec", 32'(ctl), 32'(C_LUI));
    cyc(); cyc(); chk("lui_instret", 32'(bus.instret), 3);
    bus.opcode = 7'b0010111;
    cyc(); cyc(); chk("auipc_exec", 32'(ctl), 32'(C_AUIPC));
    cyc(); cyc(); chk("auipc_instret", 32'(bus.instret), 4);

    // Load with mem_ready low for 3 cycles in MEM_RD: 8 cycles total
    bus.opcode = 7'b0000011;
    cyc(); chk("ld_decode", 32'(ctl), 32'(C_DEC));
    cyc(); chk("ld_addr", 32'(ctl), 32'(C_MADDR));
    bus.mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_wait", 32'(ctl), 32'(C_MRD));
      cyc();
    end
    bus.mem_ready = 1'b1; #1;
    chk("ld_mem_done", 32'(ctl), 32'(C_MRD));
    cyc(); chk("ld_wb", 32'(ctl), 32'(C_WBMEM));
    cyc(); chk("ld_back_fetch", 32'(ctl), 32'(C_F_GO));
    chk("ld_instret", 32'(bus.instret), 5);

    // Store, 4 cycles
    bus.opcode = 7'b0100011;
    cyc(); cyc(); cyc(); chk("st_mem", 32'(ctl), 32'(C_MWR));
    cyc(); chk("st_back_fetch", 32'(ctl), 32'(C_F_GO));
    chk("st_instret", 32'(bus.instret), 6);

    // Branch taken, then not taken
    bus.opcode = 7'b1100011; bus.branch_taken = 1'b1;
    cyc(); cyc(); chk("br_taken", 32'(ctl), 32'(C_BR_T));
    cyc(); chk("br_t_instret", 32'(bus.instret), 7);
    bus.branch_taken = 1'b0;
    cyc(); cyc(); chk("br_not_taken", 32'(ctl), 32'(C_BR_NT));
    cyc(); chk("br_nt_instret", 32'(bus.instret), 8);

    // JAL, JALR
    bus.opcode = 7'b1101111;
    cyc(); cyc(); chk("jal", 32'(ctl), 32'(C_JAL));
    cyc(); chk("jal_instret", 32'(bus.instret), 9);
    bus.opcode = 7'b1100111;
    cyc(); cyc(); chk("jalr", 32'(ctl), 32'(C_JALR));
    cyc(); chk("jalr_instret", 32'(bus.instret), 10);

    // Five more retires reach 15. The next one wraps the 4-bit counter to 0.
    bus.opcode = 7'b1101111;
    for (int i = 0; i < 5; i++) begin
      cyc(); cyc(); cyc();
    end
    chk("instret_max", 32'(bus.instret), 15);
    cyc(); cyc(); cyc();
    chk("instret_wrap", 32'(bus.instret), 0);

    // Illegal opcode: sticky, idle, no retire
    bus.opcode = 7'b1110011;
    cyc(); chk("ill_decode", 32'(ctl), 32'(C_DEC));
    cyc();
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0]; #1;
      chk("ill_flag", 32'(bus.illegal_instr), 1);
      chk("ill_ctl", 32'(ctl), 32'(C_ZERO));
      chk("ill_instret", 32'(bus.instret), 0);
      cyc();
    end
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    cyc();
    chk("ill_rst_ctl", 32'(ctl), 32'(C_ZERO));
    chk("ill_rst_flag", 32'(bus.illegal_instr), 0);
    rst = 1'b0; #1;
    chk("ill_rst_fetch", 32'(ctl), 32'(C_F_WAIT));

    // Reset during a stalled MEM_WR
    bus.mem_ready = 1'b1; bus.opcode = 7'b0100011;
    cyc(); cyc();
    bus.mem_ready = 1'b0;
    cyc(); chk("wr_stall", 32'(ctl), 32'(C_MWR));
    rst = 1'b1; #1;
    chk("wr_rst_drop", 32'(ctl), 32'(C_ZERO));
    cyc();
    rst = 1'b0; #1;
    chk("wr_rst_fetch", 32'(ctl), 32'(C_F_WAIT));
    chk("wr_rst_instret", 32'(bus.instret), 0);
    cyc();
    chk("wr_rst_hold", 32'(ctl), 32'(C_F_WAIT));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
